// File: rtl/n64_flashram_pkg.sv
// Shared state encodings, operation lengths and address helpers for the
// FlashRAM save-command service block.
package n64_flashram_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_HOLDOFF = 3'd5;

  localparam int PAGE_HALFWORDS   = 64;
  localparam int SECTOR_HALFWORDS = 8192;
  localparam int CHIP_HALFWORDS   = 65536;

  localparam logic [15:0] ERASE_VALUE = 16'hFFFF;

  // Index of the final halfword for the latched operation (length - 1).
  function automatic logic [15:0] last_index(input logic write_or_erase,
                                             input logic sector_or_all);
    if (write_or_erase)     return 16'(PAGE_HALFWORDS - 1);
    else if (sector_or_all) return 16'(SECTOR_HALFWORDS - 1);
    else                    return 16'(CHIP_HALFWORDS - 1);
  endfunction

  // Byte offset of the first halfword inside the 128 KiB save area.
  function automatic logic [16:0] start_offset(input logic [9:0] sector,
                                               input logic       sector_or_all,
                                               input logic       write_or_erase);
    if (write_or_erase)     return {sector, 7'b0};
    else if (sector_or_all) return {sector[9:7], 14'b0};
    else                    return 17'd0;
  endfunction

endpackage

// File: rtl/n64_flashram_service.sv
// Services FlashRAM page-program and erase commands by streaming halfword
// writes into the SDRAM save area as a single memory-bus requester.
module n64_flashram_service
  import n64_flashram_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 27,
  parameter logic [ADDRESS_WIDTH-1:0] SAVE_BASE   = 27'h3FE_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flashram_pending,
  output logic                     flashram_done,
  input  logic [9:0]               flashram_sector,
  input  logic                     flashram_sector_or_all,
  input  logic                     flashram_write_or_erase,
  output logic [5:0]               flashram_buffer_address,
  input  logic [15:0]              flashram_buffer_rdata,
  output logic                     mem_request,
  input  logic                     mem_ack,
  output logic                     mem_write,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [15:0]              mem_wdata
);

  logic [2:0]  r_state;
  logic [15:0] r_index;
  logic [9:0]  r_sector;
  logic        r_sector_or_all;
  logic        r_write_or_erase;
  logic [15:0] r_wdata;

  logic                     w_req;
  logic                     w_last;
  logic [16:0]              w_offset;
  logic [ADDRESS_WIDTH-1:0] w_addr;

  assign w_req    = (r_state == ST_WRITE);
  assign w_last   = (r_index == last_index(r_write_or_erase, r_sector_or_all));
  assign w_offset = start_offset(r_sector, r_sector_or_all, r_write_or_erase);
  assign w_addr   = SAVE_BASE + ADDRESS_WIDTH'(w_offset)
                  + ADDRESS_WIDTH'({r_index, 1'b0});

  // Outputs are gated so they read zero whenever no write is being offered.
  assign mem_request             = w_req;
  assign mem_write               = w_req;
  assign mem_address             = w_req ? w_addr : '0;
  assign mem_wdata               = w_req ? r_wdata : 16'd0;
  assign flashram_done           = (r_state == ST_DONE);
  assign flashram_buffer_address = r_index[5:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= ST_IDLE;
      r_index          <= 16'd0;
      r_sector         <= 10'd0;
      r_sector_or_all  <= 1'b0;
      r_write_or_erase <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flashram_pending) begin
            r_sector         <= flashram_sector;
            r_sector_or_all  <= flashram_sector_or_all;
            r_write_or_erase <= flashram_write_or_erase;
            r_index          <= 16'd0;
            r_state          <= flashram_write_or_erase ? ST_FETCH : ST_WRITE;
          end
        end
        ST_FETCH: r_state <= ST_LOAD;
        ST_LOAD:  r_state <= ST_WRITE;
        ST_WRITE: begin
          if (mem_ack) begin
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              r_index <= r_index + 16'd1;
              r_state <= r_write_or_erase ? ST_FETCH : ST_WRITE;
            end
          end
        end
        ST_DONE: r_state <= ST_HOLDOFF;
        // A pending still high from the finished command is never re-run.
        ST_HOLDOFF: begin
          if (!flashram_pending) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && flashram_pending && !flashram_write_or_erase)
      r_wdata <= ERASE_VALUE;
    else if (r_state == ST_LOAD)
      r_wdata <= flashram_buffer_rdata;
  end

endmodule

// File: tb/tb_n64_flashram_service.sv
// Directed bench for n64_flashram_service: program, sector/chip erase,
// stalled acks, pending holdoff and asynchronous reset abort.
module tb_n64_flashram_service;
  import n64_flashram_pkg::*;

  localparam logic [26:0] BASE = 27'h3FE_0000;

  logic        clk;
  logic        reset_n;
  logic        flashram_pending;
  logic        flashram_done;
  logic [9:0]  flashram_sector;
  logic        flashram_sector_or_all;
  logic        flashram_write_or_erase;
  logic [5:0]  flashram_buffer_address;
  logic [15:0] flashram_buffer_rdata;
  logic        mem_request;
  logic        mem_ack;
  logic        mem_write;
  logic [26:0] mem_address;
  logic [15:0] mem_wdata;

  int checks = 0;
  int errors = 0;

  logic [15:0] bufm [64];
  bit          ack_rand = 1'b0;

  logic [26:0] wa [$];
  logic [15:0] wd [$];
  int          done_cnt = 0;
  int          req_cnt = 0;
  int          stall_cnt = 0;
  int          stall_viol = 0;

  n64_flashram_service #(.ADDRESS_WIDTH(27), .SAVE_BASE(BASE)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .flashram_pending        (flashram_pending),
    .flashram_done           (flashram_done),
    .flashram_sector         (flashram_sector),
    .flashram_sector_or_all  (flashram_sector_or_all),
    .flashram_write_or_erase (flashram_write_or_erase),
    .flashram_buffer_address (flashram_buffer_address),
    .flashram_buffer_rdata   (flashram_buffer_rdata),
    .mem_request             (mem_request),
    .mem_ack                 (mem_ack),
    .mem_write               (mem_write),
    .mem_address             (mem_address),
    .mem_wdata               (mem_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous program buffer: data for the address seen at an edge appears just after it.
  initial begin
    logic [5:0] a;
    flashram_buffer_rdata = 16'd0;
    forever begin
      @(posedge clk);
      a = flashram_buffer_address;
      #1 flashram_buffer_rdata = bufm[a];
    end
  end

  // Memory acknowledge: always-on, or a random 0..7 cycle stall per word.
  initial begin
    int wait_left;
    wait_left = -1;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!ack_rand) begin
        mem_ack = 1'b1;
        wait_left = -1;
      end else if (!mem_request) begin
        mem_ack = 1'b0;
        wait_left = -1;
      end else begin
        if (wait_left < 0) wait_left = int'($urandom_range(0, 7));
        if (wait_left == 0) begin
          mem_ack = 1'b1;
          wait_left = -1;
        end else begin
          mem_ack = 1'b0;
          wait_left = wait_left - 1;
        end
      end
    end
  end

  // Bus monitor: records accepted writes and checks stability across stalls.
  initial begin
    bit          have_stall;
    logic [26:0] s_addr;
    logic [15:0] s_data;
    have_stall = 1'b0;
    s_addr = '0;
    s_data = '0;
    forever begin
      @(negedge clk);
      if (flashram_done) done_cnt++;
      if (mem_request) req_cnt++;
      if (have_stall && mem_request && (mem_address !== s_addr || mem_wdata !== s_data))
        stall_viol++;
      if (mem_request && mem_ack) begin
        wa.push_back(mem_address);
        wd.push_back(mem_wdata);
        have_stall = 1'b0;
      end else if (mem_request) begin
        stall_cnt++;
        have_stall = 1'b1;
        s_addr = mem_address;
        s_data = mem_wdata;
      end else begin
        have_stall = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic [9:0] s, input logic soa, input logic woe);
    @(negedge clk);
    flashram_sector         = s;
    flashram_sector_or_all  = soa;
    flashram_write_or_erase = woe;
    flashram_pending        = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (flashram_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic verify(input string tag, input int base, input int n,
                        input logic [26:0] a0, input bit is_prog);
    int bad_a;
    int bad_d;
    int got;
    logic [15:0] ed;
    bad_a = 0;
    bad_d = 0;
    got = wa.size() - base;
    chk({tag, "_count"}, 32'(got), 32'(n));
    for (int i = 0; i < n && (base + i) < wa.size(); i++) begin
      ed = is_prog ? bufm[i] : 16'hFFFF;
      if (wa[base + i] !== 27'(a0 + 27'(2 * i))) bad_a++;
      if (wd[base + i] !== ed) bad_d++;
    end
    chk({tag, "_addr_errs"}, 32'(bad_a), 32'd0);
    chk({tag, "_data_errs"}, 32'(bad_d), 32'd0);
    if (got > 0) begin
      chk({tag, "_first_addr"}, 32'(wa[base]), 32'(a0));
      chk({tag, "_last_addr"}, 32'(wa[wa.size() - 1]), 32'(27'(a0 + 27'(2 * (n - 1)))));
    end
  endtask

  initial begin
    int b;
    int d0;
    int r0;
    flashram_pending        = 1'b0;
    flashram_sector         = 10'd0;
    flashram_sector_or_all  = 1'b0;
    flashram_write_or_erase = 1'b0;
    reset_n                 = 1'b0;
    for (int i = 0; i < 64; i++) bufm[i] = 16'hA500 + 16'(i);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_request", 32'(mem_request), 32'd0);
    chk("rst_write", 32'(mem_write), 32'd0);
    chk("rst_done", 32'(flashram_done), 32'd0);
    chk("rst_address", 32'(mem_address), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_bufaddr", 32'(flashram_buffer_address), 32'd0);
    reset_n = 1'b1;

    // Program page 5 with continuous ack
    b = wa.size();
    d0 = done_cnt;
    start_cmd(10'd5, 1'b0, 1'b1);
    wait_done("prog5", 400);
    verify("prog5", b, 64, BASE + 27'h280, 1'b1);
    flashram_pending = 1'b0;
    repeat (2) @(negedge clk);
    chk("prog5_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("prog5_idle", 32'(dut.r_state), 32'(ST_IDLE));

    // Sector erase 0x1A3; input changes after latching must be ignored
    b = wa.size();
    d0 = done_cnt;
    start_cmd(10'h1A3, 1'b1, 1'b0);
    @(negedge clk);
    flashram_sector         = 10'd0;
    flashram_write_or_erase = 1'b1;
    flashram_sector_or_all  = 1'b0;
    wait_done("sect", 9000);
    verify("sect", b, 8192, BASE + 27'hC000, 1'b0);

    // Pending held 20 cycles after done: no re-execution
    r0 = req_cnt;
    repeat (20) @(negedge clk);
    chk("hold_no_requests", 32'(req_cnt - r0), 32'd0);
    chk("hold_state", 32'(dut.r_state), 32'(ST_HOLDOFF));
    chk("hold_done_pulses", 32'(done_cnt - d0), 32'd1);
    flashram_pending = 1'b0;
    @(negedge clk);
    chk("hold_idle_next", 32'(dut.r_state), 32'(ST_IDLE));

    // Chip erase, full 65536 words
    b = wa.size();
    d0 = done_cnt;
    start_cmd(10'h3FF, 1'b0, 1'b0);
    wait_done("chip", 66000);
    flashram_pending = 1'b0;
    repeat (3) @(negedge clk);
    verify("chip", b, 65536, BASE, 1'b0);
    chk("chip_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Program page 0x3FF with random ack stalls
    for (int i = 0; i < 64; i++) bufm[i] = 16'h5A00 ^ 16'(i * 37);
    ack_rand = 1'b1;
    b = wa.size();
    d0 = done_cnt;
    r0 = stall_viol;
    start_cmd(10'h3FF, 1'b1, 1'b1);
    wait_done("stall", 1500);
    flashram_pending = 1'b0;
    repeat (2) @(negedge clk);
    verify("stall", b, 64, BASE + 27'h1FF80, 1'b1);
    chk("stall_violations", 32'(stall_viol - r0), 32'd0);
    chk("stall_seen", 32'(stall_cnt > 0), 32'd1);
    ack_rand = 1'b0;

    // Reset mid chip erase aborts immediately
    d0 = done_cnt;
    start_cmd(10'd0, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    chk("abort_busy", 32'(mem_request), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_request", 32'(mem_request), 32'd0);
    chk("abort_done", 32'(flashram_done), 32'd0);
    flashram_pending = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    reset_n = 1'b1;

    // Fresh program after the abort
    for (int i = 0; i < 64; i++) bufm[i] = ~(16'h0100 + 16'(i));
    b = wa.size();
    d0 = done_cnt;
    start_cmd(10'd2, 1'b0, 1'b1);
    wait_done("post", 400);
    flashram_pending = 1'b0;
    repeat (2) @(negedge clk);
    verify("post", b, 64, BASE + 27'h100, 1'b1);
    chk("post_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("post_idle", 32'(dut.r_state), 32'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
